// File: rtl/fifo_rd_streamer.sv
// Read-side drain for an async FIFO: registered read strobe, one-word read latency,
// and a 2-entry skid buffer that presents a valid/ready output stream.
module fifo_rd_streamer #(
  parameter int DSIZE  = 8,
  parameter int CWIDTH = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              en,
  input  logic              rempty,
  input  logic [DSIZE-1:0]  rdata,
  output logic              rinc,
  output logic              m_valid,
  output logic [DSIZE-1:0]  m_data,
  input  logic              m_ready,
  output logic [CWIDTH-1:0] xfer_cnt,
  output logic              busy
);

  logic [1:0]        occ_q, occ_d;
  logic              infl_q, infl_d;
  logic              rinc_q, rinc_d;
  logic [DSIZE-1:0]  head_q, head_d;
  logic [DSIZE-1:0]  tail_q, tail_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              push, pop;

  // The strobe decision is registered; masking with the live empty flag keeps a
  // FIFO that just went empty from being popped, and the masked strobe is what
  // becomes the in-flight word.
  assign rinc     = rinc_q && !rempty;
  assign push     = infl_q;
  assign pop      = (occ_q != 2'd0) && m_ready;
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign xfer_cnt = cnt_q;
  assign busy     = (occ_q != 2'd0) || infl_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = rdata;
        else               tail_d = rdata;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = rdata;
        end else begin
          head_d = tail_q;
          tail_d = rdata;
        end
      end
      default: ;
    endcase
    infl_d = rinc;
    rinc_d = en && !rempty && (({1'b0, occ_d} + {2'b00, infl_d}) < 3'd2);
    cnt_d  = cnt_q + {{(CWIDTH-1){1'b0}}, pop};
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q  <= '0;
      infl_q <= 1'b0;
      rinc_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      rinc_q <= rinc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
